fir_sample_feeder: RTL and testbench
====================================

// Module: fir_sample_feeder
// PURPOSE
//  Upstream stage of the 80-tap FIR filter: buffers incoming 8-bit samples in a small FIFO and
//  drives the filter's input_sig/ready pair. Keeps ready high for whole 20-cycle compute frames
//  and presents exactly one new sample per frame, aligned to the filter's load cycle.
//  Also flags underruns and gives downstream a strobe for when the filter result is updated.
// PARAMETERS
//  DATA_W       8   sample width, two's complement
//  FIFO_DEPTH   16  FIFO entries; power of 2, >= 2
//  CALC_CYCLES  20  filter compute cycles per sample (80 taps / 4 per cycle)
//  START_LEVEL  4   FIFO level needed to leave IDLE; 1..FIFO_DEPTH
// PORTS
//  clk           in   1                    rising-edge clock
//  rst           in   1                    asynchronous, active-high reset
//  enable        in   1                    run request; level-sensitive
//  in_data       in   DATA_W               sample from source (signed)
//  in_valid      in   1                    source has a sample
//  in_ready      out  1                    FIFO can accept; transfer when in_valid & in_ready
//  fir_sig       out  DATA_W               to filter input_sig; registered
//  fir_ready     out  1                    to filter ready; registered
//  frame_done    out  1                    1-cycle pulse: filter result register was just updated
//  fifo_level    out  $clog2(FIFO_DEPTH)+1 current FIFO occupancy
//  underrun      out  1                    sticky: frame started with an empty FIFO
//  clr_underrun  in   1                    synchronous clear of underrun
// BEHAVIOUR
//  Reset (async): state=IDLE, FIFO empty, fifo_level=0, phase=0, fir_sig=0, fir_ready=0,
//   frame_done=0, underrun=0. in_ready=1 once reset is released. Reset mid-frame aborts the
//   frame immediately and drops all buffered samples.
//  FIFO: in_ready = (level != FIFO_DEPTH), combinational from registered level. Push and pop in
//   the same cycle are both allowed; the level does not change. Pointers wrap modulo FIFO_DEPTH.
//  States:
//   IDLE: fir_ready=0, fir_sig=0. The filter shifts in zeros every cycle, which flushes its
//    delay line. Go to RUN when enable & level >= START_LEVEL. On that edge: pop the head into
//    fir_sig, set fir_ready=1, set phase=0.
//   RUN: fir_ready=1. phase counts 0..CALC_CYCLES-1, one step per cycle, in lockstep with the
//    filter index (0,4,..,76). fir_sig is held constant for the whole frame. The filter loads
//    fir_sig and updates its result on the edge that ends phase CALC_CYCLES-1. On that edge:
//    - frame_done is registered to 1, so it is high for the single following cycle.
//    - If enable=1: pop the next sample into fir_sig and wrap phase to 0. If the FIFO is empty
//      (registered level=0), load fir_sig=0 instead, set underrun=1 and stay in RUN.
//    - If enable=0: go to IDLE, fir_sig=0, fir_ready=0, no pop.
//   Deasserting enable mid-frame has no effect until the frame ends; frames are never truncated.
//  A push in the same cycle as an empty-FIFO frame boundary is not forwarded. The frame
//   zero-stuffs, and the pushed sample is used for the next frame.
//  Steady throughput: 1 sample / CALC_CYCLES cycles. Latency: a sample popped at edge E is
//   consumed by the filter at E + CALC_CYCLES.
//  underrun: set has priority over clr_underrun when both happen in the same cycle.
//  fifo_level never exceeds FIFO_DEPTH. No writes are accepted while full; the source is
//   back-pressured and no data is lost.
// TESTING
//  1. Reset, push 4 samples (0x01,0x02,0x03,0x04), enable=1 -> RUN on the next edge,
//     fir_sig=0x01 for 20 cycles, then 0x02; frame_done pulses every 20 cycles.
//  2. Feed the filter with coefficient tap0=0x40 and a single impulse 0x7F followed by zeros
//     -> the first frame_done after impulse load shows output_sig=0x1F; later taps follow.
//  3. Start with 4 samples, send no more -> frames 5+ have fir_sig=0, underrun=1, fir_ready
//     stays 1; clr_underrun=1 with a non-empty FIFO -> underrun=0.
//  4. Push 16 samples with enable=0 -> level=16, in_ready=0, a 17th in_valid is held off;
//     one pop -> in_ready=1 in the next cycle.
//  5. Drop enable at phase 5 -> frame finishes (phase 19), frame_done pulses, then IDLE with
//     fir_ready=0 and fir_sig=0; no sample popped.
//  6. Assert rst at phase 10 with level=7 -> all outputs are at reset values without waiting
//     for a clock edge; level=0 after release.

Source files
------------

// File: rtl/fir_sample_feeder.sv
// Sample FIFO and frame sequencer in front of the 80-tap FIR filter.
// Holds fir_ready high for whole compute frames and presents one new sample per frame.
module fir_sample_feeder #(
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int CALC_CYCLES = 20,
    parameter int START_LEVEL = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_W-1:0]             fir_sig,
    output logic                          fir_ready,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    input  logic                          clr_underrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int PH_W  = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;

    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] START_LVL = LVL_W'(START_LEVEL);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(CALC_CYCLES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [LVL_W-1:0]    r_level;
    logic [PH_W-1:0]     r_phase;
    logic [DATA_W-1:0]   r_fir_sig;
    logic                r_fir_ready;
    logic                r_frame_done;
    logic                r_underrun;

    logic                w_in_ready;
    logic                w_push;
    logic                w_empty;
    logic                w_start;
    logic                w_frame_end;
    logic                w_pop;
    logic                w_underrun_set;
    logic [DATA_W-1:0]   w_head;

    assign w_in_ready     = (r_level != FULL_LVL);
    assign w_push         = in_valid & w_in_ready;
    assign w_empty        = (r_level == '0);
    assign w_start        = (r_state == S_IDLE) && enable && (r_level >= START_LVL);
    assign w_frame_end    = (r_state == S_RUN) && (r_phase == PH_LAST);
    // Empty is judged on the registered level, so a same-cycle push is never forwarded.
    assign w_pop          = w_start | (w_frame_end & enable & ~w_empty);
    assign w_underrun_set = w_frame_end & enable & w_empty;
    assign w_head         = r_mem[r_rd_ptr];

    // Storage is left unreset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_phase      <= '0;
            r_fir_sig    <= '0;
            r_fir_ready  <= 1'b0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_underrun_set) begin
                r_underrun <= 1'b1;
            end else if (clr_underrun) begin
                r_underrun <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state     <= S_RUN;
                        r_fir_sig   <= w_head;
                        r_fir_ready <= 1'b1;
                        r_phase     <= '0;
                    end
                end
                S_RUN: begin
                    if (w_frame_end) begin
                        r_phase <= '0;
                        if (enable) begin
                            r_fir_sig <= w_empty ? '0 : w_head;
                        end else begin
                            r_state     <= S_IDLE;
                            r_fir_sig   <= '0;
                            r_fir_ready <= 1'b0;
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign fir_sig    = r_fir_sig;
    assign fir_ready  = r_fir_ready;
    assign frame_done = r_frame_done;
    assign fifo_level = r_level;
    assign underrun   = r_underrun;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed plus randomized bench for fir_sample_feeder against a queue-based frame model.
module tb_fir_sample_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] fir_sig;
    logic       fir_ready;
    logic       frame_done;
    logic [4:0] fifo_level;
    logic       underrun;
    logic       clr_underrun = 1'b0;

    int checks   = 0;
    int failures = 0;

    fir_sample_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .fir_sig      (fir_sig),
        .fir_ready    (fir_ready),
        .frame_done   (frame_done),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of buffered samples plus the frame currently being computed.
    logic [7:0] q[$];
    bit         m_run;
    int         m_left;      // cycles remaining in the current frame, including this one
    logic [7:0] m_sig;
    bit         m_done;
    bit         m_ur;
    int         frames;

    task automatic model_reset();
        q.delete();
        m_run  = 0;
        m_left = 0;
        m_sig  = '0;
        m_done = 0;
        m_ur   = 0;
    endtask

    task automatic model_edge();
        bit frame_over;
        bit push;
        bit ur_set;
        frame_over = m_run && (m_left == 1);
        push       = in_valid && (q.size() < 16);
        ur_set     = 0;
        m_done     = frame_over;
        if (!m_run) begin
            if (enable && q.size() >= 4) begin
                m_sig  = q.pop_front();
                m_run  = 1;
                m_left = 20;
            end
        end else if (frame_over) begin
            if (enable) begin
                if (q.size() == 0) begin
                    m_sig  = '0;
                    ur_set = 1;
                end else begin
                    m_sig = q.pop_front();
                end
                m_left = 20;
            end else begin
                m_run = 0;
                m_sig = '0;
            end
        end else begin
            m_left--;
        end
        if (ur_set) m_ur = 1;
        else if (clr_underrun) m_ur = 0;
        if (push) q.push_back(in_data);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("level",      fifo_level, q.size());
        chk("in_ready",   in_ready,   (q.size() != 16));
        chk("fir_sig",    fir_sig,    m_sig);
        chk("fir_ready",  fir_ready,  m_run);
        chk("frame_done", frame_done, m_done);
        chk("underrun",   underrun,   m_ur);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (m_done) begin
            frames++;
            $display("frame %0d done: next fir_sig=%02h level=%0d underrun=%0b",
                     frames, m_sig, q.size(), m_ur);
        end
    endtask

    // Asserts reset between edges and checks outputs before any clock edge arrives.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_fir_ready_async", fir_ready, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        int n;
        model_reset();
        frames = 0;
        #1;
        check_all();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
        chk("in_ready_after_reset", in_ready, 1'b1);

        // Four samples buffered, then start: first frame carries 0x01, second 0x02.
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        enable   = 1'b1;
        tick();
        chk("t1_first_sig", fir_sig, 8'h01);
        chk("t1_ready", fir_ready, 1'b1);
        for (int i = 0; i < 20; i++) tick();
        chk("t1_second_sig", fir_sig, 8'h02);
        chk("t1_frame_done", frame_done, 1'b1);
        tick();
        chk("t1_done_one_cycle", frame_done, 1'b0);

        // No further samples: the fifth frame zero-stuffs and flags underrun.
        for (int i = 0; i < 59; i++) tick();
        chk("t3_underrun", underrun, 1'b1);
        chk("t3_sig_zero", fir_sig, 8'h00);
        chk("t3_ready_held", fir_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        in_valid     = 1'b0;
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
        chk("t3_cleared", underrun, 1'b0);

        // Drop enable mid-frame: the frame completes, then idle with no pop.
        n = 0;
        while (m_left != 15 && n < 40) begin
            tick();
            n++;
        end
        chk("t5_reached_phase5", (n < 40), 1'b1);
        enable = 1'b0;
        n = 0;
        while (m_run && n < 40) begin
            tick();
            n++;
        end
        chk("t5_frame_len", n, 15);
        chk("t5_idle_ready", fir_ready, 1'b0);
        chk("t5_idle_sig", fir_sig, 8'h00);
        tick();

        // Fill to full while disabled; the extra offers are held off.
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            tick();
        end
        chk("t4_full_level", fifo_level, 5'd16);
        chk("t4_full_ready", in_ready, 1'b0);
        enable = 1'b1;
        tick();
        chk("t4_after_pop_level", fifo_level, 5'd15);
        chk("t4_after_pop_ready", in_ready, 1'b1);
        in_valid = 1'b0;

        // Randomized traffic with occasional enable toggles and underrun clears.
        for (int i = 0; i < 1500; i++) begin
            in_valid     = ($urandom_range(0, 15) == 0);
            in_data      = 8'($urandom);
            clr_underrun = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            tick();
        end
        in_valid     = 1'b0;
        clr_underrun = 1'b0;
        enable       = 1'b0;
        tick();

        // Reset mid-frame with samples buffered.
        async_reset();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hA0 + i);
            tick();
        end
        in_valid = 1'b0;
        enable   = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        chk("t6_level_before", fifo_level, 5'd7);
        async_reset();
        chk("t6_level_after", fifo_level, 5'd0);
        chk("t6_sig_after", fir_sig, 8'h00);
        enable = 1'b0;
        tick();
        chk("t6_ready_after", in_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
